// File: rtl/cam_buf_pkg.sv
// Shared definitions for the camera frame buffer: register map, STATUS layout,
// and a width helper used by the top level and the byte packer.
package cam_buf_pkg;

  localparam logic [1:0] REG_CTRL      = 2'd0;
  localparam logic [1:0] REG_STATUS    = 2'd1;
  localparam logic [1:0] REG_RELEASE   = 2'd2;
  localparam logic [1:0] REG_FRAME_CNT = 2'd3;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_OVF_CLR_BIT = 1;

  localparam int ST_FULL_LSB = 0;
  localparam int ST_BANK_LSB = 8;
  localparam int ST_OVF_BIT  = 16;

  localparam int FRAME_CNT_W = 16;

  // Index width that stays at least 1 bit for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Packs camera bytes MSB-first into BPW-byte words; emits a one-cycle word_vld.
// A flush zero-pads and emits a partial word; clear discards any partial word.
module cam_byte_packer
  import cam_buf_pkg::*;
#(
  parameter int BPW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_flush,
  input  logic             i_byte_vld,
  input  logic [7:0]       i_byte,
  output logic             o_word_vld,
  output logic [8*BPW-1:0] o_word
);
  localparam int DW = 8 * BPW;
  localparam int CW = idx_width(BPW);

  logic [DW-1:0] r_shift;
  logic [CW-1:0] r_cnt;
  logic          r_word_vld;
  logic [DW-1:0] r_word;
  logic [DW-1:0] w_shift_nxt;

  assign w_shift_nxt = (r_shift << 8) | DW'(i_byte);
  assign o_word_vld  = r_word_vld;
  assign o_word      = r_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_word_vld <= 1'b0;
      r_word     <= '0;
    end else begin
      r_word_vld <= 1'b0;
      if (i_clr) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (i_byte_vld) begin
        if (r_cnt == CW'(BPW - 1)) begin
          r_word     <= w_shift_nxt;
          r_word_vld <= 1'b1;
          r_shift    <= '0;
          r_cnt      <= '0;
        end else begin
          r_shift <= w_shift_nxt;
          r_cnt   <= r_cnt + CW'(1);
        end
      end else if (i_flush && (r_cnt != '0)) begin
        // Left-align the collected bytes so the missing low bytes read as zero.
        r_word     <= r_shift << (8 * (BPW - int'(r_cnt)));
        r_word_vld <= 1'b1;
        r_shift    <= '0;
        r_cnt      <= '0;
      end
    end
  end

endmodule

// File: rtl/cam_frame_buffer.sv
// Camera capture buffer: packed words fill NUM_BANKS banks round-robin with a
// full/release handshake, read back over Wishbone. Option: CAM_BUF_LINE_FLUSH_EN.
module cam_frame_buffer
  import cam_buf_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 512,
  parameter int NUM_BANKS = 4,
  parameter int ADDRWIDTH = 11
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_n_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_RAM_CYC_i,
  input  logic                 WBs_CTL_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic [31:0]          WBs_DAT_i,
  output logic [DATAWIDTH-1:0] WBs_RAM_DAT_o,
  output logic [31:0]          WBs_CTL_DAT_o,
  output logic                 WBs_ACK_o,
  input  logic                 CAM_VSYNC_i,
  input  logic                 CAM_HREF_i,
  input  logic [7:0]           CAM_DAT_i,
  input  logic                 CAM_DAT_VLD_i,
  output logic                 irq_o
);
  localparam int BPW   = DATAWIDTH / 8;
  localparam int BANKW = idx_width(NUM_BANKS);
  localparam int WORDW = idx_width(DEPTH);

  logic [DATAWIDTH-1:0]   r_mem [NUM_BANKS*DEPTH];
  logic                   r_en, r_ovf, r_vsync, r_ack;
  logic [NUM_BANKS-1:0]   r_full;
  logic [BANKW-1:0]       r_bank;
  logic [WORDW-1:0]       r_addr;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [DATAWIDTH-1:0]   r_ram_dat;
  logic [31:0]            r_ctl_dat;

  logic                 w_accept, w_vs_rise, w_vs_fall, w_flush, w_pk_clr;
  logic                 w_word_vld, w_wr, w_drop, w_bank_done;
  logic [DATAWIDTH-1:0] w_word;
  logic                 w_access, w_ctl_wr, w_ovf_clr;
  logic [NUM_BANKS-1:0] w_full_set, w_full_clr;
  logic [31:0]          w_ctl_rdata;
  logic                 w_unused_ok;

  assign w_accept  = CAM_DAT_VLD_i & CAM_HREF_i & CAM_VSYNC_i & r_en;
  assign w_vs_rise = CAM_VSYNC_i & ~r_vsync;
  assign w_vs_fall = ~CAM_VSYNC_i & r_vsync;
  assign w_pk_clr  = w_vs_rise | ~r_en;

`ifdef CAM_BUF_LINE_FLUSH_EN
  logic r_href;
  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_n_i) r_href <= 1'b0;
    else              r_href <= CAM_HREF_i;
  end
  assign w_flush = r_href & ~CAM_HREF_i;
`else
  assign w_flush = 1'b0;
`endif

  cam_byte_packer #(.BPW(BPW)) u_packer (
    .clk        (WBs_CLK_i),
    .rst_n      (WBs_RST_n_i),
    .i_clr      (w_pk_clr),
    .i_flush    (w_flush),
    .i_byte_vld (w_accept),
    .i_byte     (CAM_DAT_i),
    .o_word_vld (w_word_vld),
    .o_word     (w_word)
  );

  // A word aimed at a bank the host still owns is dropped and flagged.
  assign w_drop      = w_word_vld & r_full[r_bank];
  assign w_wr        = w_word_vld & ~r_full[r_bank];
  assign w_bank_done = w_wr & (r_addr == WORDW'(DEPTH - 1));
  assign w_full_set  = w_bank_done ? (NUM_BANKS'(1) << r_bank) : '0;

  assign w_access   = (WBs_RAM_CYC_i | WBs_CTL_CYC_i) & WBs_STB_i & ~r_ack;
  assign w_ctl_wr   = w_access & WBs_CTL_CYC_i & ~WBs_RAM_CYC_i & WBs_WE_i & WBs_BYTE_STB_i[0];
  assign w_full_clr = (w_ctl_wr && WBs_ADR_i[1:0] == REG_RELEASE) ? WBs_DAT_i[NUM_BANKS-1:0] : '0;
  assign w_ovf_clr  = w_ctl_wr && (WBs_ADR_i[1:0] == REG_CTRL) && WBs_DAT_i[CTRL_OVF_CLR_BIT];
  assign w_unused_ok = &{1'b0, WBs_BYTE_STB_i, WBs_DAT_i};

  always_comb begin
    w_ctl_rdata = '0;
    case (WBs_ADR_i[1:0])
      REG_CTRL:   w_ctl_rdata[CTRL_EN_BIT] = r_en;
      REG_STATUS: begin
        w_ctl_rdata[ST_FULL_LSB +: NUM_BANKS] = r_full;
        w_ctl_rdata[ST_BANK_LSB +: BANKW]     = r_bank;
        w_ctl_rdata[ST_OVF_BIT]               = r_ovf;
      end
      REG_FRAME_CNT: w_ctl_rdata[FRAME_CNT_W-1:0] = r_frame_cnt;
      default: ;
    endcase
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (w_wr) r_mem[{r_bank, r_addr}] <= w_word;
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_n_i) begin
      r_en        <= 1'b0;
      r_ovf       <= 1'b0;
      r_vsync     <= 1'b0;
      r_ack       <= 1'b0;
      r_full      <= '0;
      r_bank      <= '0;
      r_addr      <= '0;
      r_frame_cnt <= '0;
      r_ram_dat   <= '0;
      r_ctl_dat   <= '0;
    end else begin
      r_vsync <= CAM_VSYNC_i;
      r_ack   <= w_access;
      // Setting beats clearing for both the full flags and OVF.
      r_full  <= (r_full & ~w_full_clr) | w_full_set;
      r_ovf   <= (r_ovf & ~w_ovf_clr) | w_drop;
      if (w_ctl_wr && WBs_ADR_i[1:0] == REG_CTRL) r_en <= WBs_DAT_i[CTRL_EN_BIT];
      if (w_vs_fall) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      if (w_bank_done) r_bank <= r_bank + BANKW'(1);
      // Bank and word counters are power-of-2 wide, so they wrap on their own.
      if (w_vs_rise)  r_addr <= '0;
      else if (w_wr)  r_addr <= r_addr + WORDW'(1);
      if (w_access & WBs_RAM_CYC_i & ~WBs_WE_i) r_ram_dat <= r_mem[WBs_ADR_i];
      if (w_access & WBs_CTL_CYC_i & ~WBs_WE_i) r_ctl_dat <= w_ctl_rdata;
    end
  end

  assign WBs_RAM_DAT_o = r_ram_dat;
  assign WBs_CTL_DAT_o = r_ctl_dat;
  assign WBs_ACK_o     = r_ack;
  assign irq_o         = |r_full;

endmodule

// File: tb/tb_cam_frame_buffer.sv
// Randomised bench for cam_frame_buffer: a queue-based reference model predicts
// bus read data; a monitor checks every read acknowledge against it.
`timescale 1ns/1ps
module tb_cam_frame_buffer;
  localparam int DW = 32, BPW = 4, DEPTH = 16, NB = 4, AW = 6;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] adr = '0;
  logic ram_cyc = 0, ctl_cyc = 0, stb = 0, we = 0;
  logic [3:0] bstb = '0;
  logic [31:0] dat_i = '0;
  logic [DW-1:0] ram_dat;
  logic [31:0] ctl_dat;
  logic ack, irq;
  logic vsync = 0, href = 0, cvld = 0;
  logic [7:0] cdat = '0;

  always #5 clk = ~clk;

  cam_frame_buffer #(.DATAWIDTH(DW), .DEPTH(DEPTH), .NUM_BANKS(NB), .ADDRWIDTH(AW)) dut (
    .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .WBs_ADR_i(adr), .WBs_RAM_CYC_i(ram_cyc),
    .WBs_CTL_CYC_i(ctl_cyc), .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_BYTE_STB_i(bstb),
    .WBs_DAT_i(dat_i), .WBs_RAM_DAT_o(ram_dat), .WBs_CTL_DAT_o(ctl_dat), .WBs_ACK_o(ack),
    .CAM_VSYNC_i(vsync), .CAM_HREF_i(href), .CAM_DAT_i(cdat), .CAM_DAT_VLD_i(cvld), .irq_o(irq)
  );

  int total = 0, bad = 0;

  typedef struct { string nm; bit ram; logic [31:0] exp; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // Reference model state
  logic [31:0] m_mem [NB*DEPTH];
  logic [NB-1:0] m_full = '0;
  bit m_ovf = 0, m_en = 0;
  int m_bank = 0, m_addr = 0, m_frame = 0;
  logic [7:0] m_part[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic void m_word(input logic [31:0] w);
    if (m_full[m_bank]) m_ovf = 1'b1;
    else begin
      m_mem[m_bank*DEPTH + m_addr] = w;
      m_addr++;
      if (m_addr == DEPTH) begin
        m_addr = 0;
        m_full[m_bank] = 1'b1;
        m_bank = (m_bank + 1) % NB;
      end
    end
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    logic [31:0] w = '0;
    m_part.push_back(b);
    if (m_part.size() == BPW) begin
      foreach (m_part[i]) w = (w << 8) | 32'(m_part[i]);
      m_part.delete();
      m_word(w);
    end
  endfunction

  function automatic void m_flush();
    logic [31:0] w = '0;
    if (m_part.size() != 0) begin
      for (int i = 0; i < BPW; i++) w = (w << 8) | ((i < m_part.size()) ? 32'(m_part[i]) : 32'd0);
      m_part.delete();
      m_word(w);
    end
  endfunction

  function automatic logic [31:0] m_status();
    return 32'(m_full) | (32'(m_bank) << 8) | (32'(m_ovf) << 16);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    cdat = b; cvld = 1'b1;
    if (vsync && href && m_en) m_byte(b);
    @(posedge clk); #1;
    cvld = 1'b0;
    repeat ($urandom_range(0, 1)) @(posedge clk);
  endtask

  task automatic wb_cycle(input bit ram, input bit wr, input logic [AW-1:0] a, input logic [31:0] d);
    bit got = 0;
    @(posedge clk); #1;
    ram_cyc = ram; ctl_cyc = !ram; stb = 1'b1; we = wr; adr = a; dat_i = d; bstb = 4'hF;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL wb_ack_timeout: adr %0d got no ack in 4 cycles, expected one", a);
      if (!wr && sbq.size() != 0) void'(sbq.pop_back());
    end
    @(negedge clk); #1;
    ram_cyc = 0; ctl_cyc = 0; stb = 0; we = 0;
  endtask

  task automatic rd_ram(input string nm, input int a, input logic [31:0] exp);
    sbq.push_back('{nm, 1'b1, exp});
    wb_cycle(1'b1, 1'b0, AW'(a), 32'd0);
  endtask

  task automatic rd_ctl(input string nm, input logic [1:0] r, input logic [31:0] exp);
    sbq.push_back('{nm, 1'b0, exp});
    wb_cycle(1'b0, 1'b0, AW'(r), 32'd0);
  endtask

  task automatic wr_ctrl(input bit en, input bit ovf_clr);
    wb_cycle(1'b0, 1'b1, AW'(0), {30'd0, ovf_clr, en});
    m_en = en;
    if (!en) m_part.delete();
    if (ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic wr_release(input logic [NB-1:0] mask);
    wb_cycle(1'b0, 1'b1, AW'(2), 32'(mask));
    m_full &= ~mask;
  endtask

  task automatic set_vsync(input logic v);
    @(posedge clk); #1;
    if (v && !vsync) begin m_part.delete(); m_addr = 0; end
    if (!v && vsync) m_frame = (m_frame + 1) & 16'hFFFF;
    vsync = v;
    repeat (2) @(posedge clk);
  endtask

  // Last byte of a bank in cycle N, RELEASE of that bank strobed in cycle N+1.
  task automatic collide_release(input logic [7:0] b, input logic [NB-1:0] mask);
    @(posedge clk); #1;
    cdat = b; cvld = 1'b1;
    m_full &= ~mask;
    m_byte(b);
    @(posedge clk); #1;
    cvld = 1'b0;
    ctl_cyc = 1; stb = 1; we = 1; adr = AW'(2); dat_i = 32'(mask); bstb = 4'hF;
    @(posedge clk); #1;
    chk("release_collide_ack", 32'(ack), 32'd1);
    @(negedge clk); #1;
    ctl_cyc = 0; stb = 0; we = 0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ram_dat"}, ram_dat, 32'd0);
    chk({tag, "_ctl_dat"}, ctl_dat, 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  always @(negedge clk) begin
    if (ack && !we) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected_ack: ack with no pending read, expected none");
      end else begin
        mon_e = sbq.pop_front();
        chk(mon_e.nm, mon_e.ram ? ram_dat : ctl_dat, mon_e.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2ms, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int guard;
    repeat (3) @(posedge clk); #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    rd_ctl("reset_status", 2'd1, 32'd0);
    rd_ctl("reset_ctrl", 2'd0, 32'd0);
    rd_ctl("reset_frame", 2'd3, 32'd0);

    // Full frame across all banks
    wr_ctrl(1'b1, 1'b0);
    rd_ctl("ctrl_en", 2'd0, 32'd1);
    set_vsync(1'b1);
    href = 1'b1;
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    for (int i = 4; i < NB*DEPTH*BPW; i++) send_byte(8'($urandom));
    rd_ctl("frame_status", 2'd1, m_status());
    chk("frame_irq", 32'(irq), 32'(|m_full));
    chk("frame_full_mask", 32'(m_full), 32'hF);
    rd_ram("first_word", 0, 32'h01020304);
    for (int i = 0; i < 6; i++) begin
      base = $urandom_range(1, NB*DEPTH-1);
      rd_ram("rand_word", base, m_mem[base]);
    end

    // Overflow while all banks are full, then release bank 0
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    rd_ctl("ovf_status", 2'd1, m_status());
    wr_release(4'b0001);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    rd_ram("after_release_word", 0, m_mem[0]);
    rd_ctl("after_release_status", 2'd1, m_status());
    wr_ctrl(1'b1, 1'b1);
    rd_ctl("ovf_cleared_status", 2'd1, m_status());

    // Release of bank 2 collides with its final write
    wr_release(4'hF);
    guard = 0;
    while (!(m_bank == 2 && m_addr == DEPTH-1 && m_part.size() == BPW-1) && guard < 1000) begin
      send_byte(8'($urandom));
      guard++;
    end
    collide_release(8'($urandom), 4'b0100);
    repeat (2) @(posedge clk);
    rd_ctl("collide_status", 2'd1, m_status());
    chk("collide_irq", 32'(irq), 32'(|m_full));

    // Partial word across a line boundary
    wr_release(4'hF);
    set_vsync(1'b0);
    set_vsync(1'b1);
    base = m_bank * DEPTH;
    for (int i = 8'h0A; i <= 8'h0F; i++) send_byte(8'(i));
    @(posedge clk); #1;
    href = 1'b0;
`ifdef CAM_BUF_LINE_FLUSH_EN
    m_flush();
`endif
    repeat (3) @(posedge clk); #1;
    href = 1'b1;
    for (int i = 8'h10; i <= 8'h13; i++) send_byte(8'(i));
    rd_ram("line_w0", base, 32'h0A0B0C0D);
`ifdef CAM_BUF_LINE_FLUSH_EN
    rd_ram("line_w1", base + 1, 32'h0E0F0000);
    rd_ram("line_w2", base + 2, 32'h10111213);
`else
    rd_ram("line_w1", base + 1, 32'h0E0F1011);
`endif
    rd_ram("line_model_w1", base + 1, m_mem[base + 1]);

    // VSYNC restart after three words and a partial one
    for (int i = 0; i < 3*BPW + 2; i++) send_byte(8'($urandom));
    set_vsync(1'b0);
    set_vsync(1'b1);
    base = m_bank * DEPTH;
    for (int i = 0; i < BPW; i++) send_byte(8'($urandom));
    rd_ram("vsync_restart_word", base, m_mem[base]);
    rd_ctl("vsync_status", 2'd1, m_status());
    rd_ctl("frame_cnt", 2'd3, 32'(m_frame));

    // Back-to-back STATUS reads with STB held
    for (int i = 0; i < 3; i++) sbq.push_back('{"b2b_status", 1'b0, m_status()});
    @(posedge clk); #1;
    ctl_cyc = 1; stb = 1; we = 0; adr = AW'(1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("b2b_ack_pattern", 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    ctl_cyc = 0; stb = 0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a word with a bank full
    guard = 0;
    while (m_full == '0 && guard < 200) begin
      send_byte(8'($urandom));
      guard++;
    end
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    chk("pre_reset_irq", 32'(irq), 32'(|m_full));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_outputs_zero("midreset");
    rst_n = 1'b1;
    m_full = '0; m_ovf = 0; m_bank = 0; m_addr = 0; m_frame = 0; m_en = 0;
    m_part.delete();
    rd_ctl("post_reset_status", 2'd1, 32'd0);
    rd_ctl("post_reset_frame", 2'd3, 32'd0);

    // Bytes while disabled are ignored
    for (int i = 0; i < BPW; i++) send_byte(8'($urandom));
    wr_ctrl(1'b1, 1'b0);
    for (int i = 0; i < BPW; i++) send_byte(8'($urandom));
    rd_ram("enabled_word", 0, m_mem[0]);
    rd_ctl("enabled_status", 2'd1, m_status());

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
